// File: rtl/msx_bus_initiator_if.sv
// Host request/done handshake plus MSX cartridge slot signals of the bus initiator.
// The master view is the initiator itself; the slave view is the host/slot side.
interface msx_bus_initiator_if;
  logic        req;
  logic        ready;
  logic [1:0]  op;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [3:0]  page_sel;
  logic [7:0]  rdata;
  logic        done;
  logic        err;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  d_in;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        sltsl_n;
  logic        wait_n;

  modport master (
    input  req, op, addr, wdata, page_sel, d_in, wait_n,
    output ready, rdata, done, err, a, d_out, d_oe,
           mreq_n, iorq_n, rd_n, wr_n, sltsl_n
  );

  modport slave (
    output req, op, addr, wdata, page_sel, d_in, wait_n,
    input  ready, rdata, done, err, a, d_out, d_oe,
           mreq_n, iorq_n, rd_n, wr_n, sltsl_n
  );
endinterface

// File: rtl/msx_bus_initiator.sv
// MSX slot bus master: turns a req/done handshake into Z80-timed memory and I/O cycles.
// Every output is a flop so reset releases the strobes without a glitch.
module msx_bus_initiator #(
  parameter int IO_WAITS     = 1,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  msx_bus_initiator_if.master bus
);
  localparam int CW = (WAIT_TIMEOUT > 255) ? $clog2(WAIT_TIMEOUT + 1) : 8;
  localparam int FW = (IO_WAITS > 1) ? $clog2(IO_WAITS) : 1;
  localparam logic [CW-1:0] TO_LIM  = CW'(WAIT_TIMEOUT);
  localparam logic [FW-1:0] FW_INIT = (IO_WAITS > 0) ? FW'(IO_WAITS - 1) : '0;

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_TE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;       // [1]=I/O, [0]=write
  logic            sel_q, sel_d;
  logic [15:0]     a_q, a_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            doe_q, doe_d;
  logic            mreq_n_q, mreq_n_d;
  logic            iorq_n_q, iorq_n_d;
  logic            rd_n_q, rd_n_d;
  logic            wr_n_q, wr_n_d;
  logic            sltsl_n_q, sltsl_n_d;
  logic            strobe_on;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      sel_q     <= 1'b0;
      a_q       <= '0;
      dout_q    <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      fcnt_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      doe_q     <= 1'b0;
      mreq_n_q  <= 1'b1;
      iorq_n_q  <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      sltsl_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sel_q     <= sel_d;
      a_q       <= a_d;
      dout_q    <= dout_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      doe_q     <= doe_d;
      mreq_n_q  <= mreq_n_d;
      iorq_n_q  <= iorq_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      sltsl_n_q <= sltsl_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    a_d     = a_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          state_d = S_T1;
          op_d    = bus.op;
          a_d     = bus.addr;
          sel_d   = !bus.op[1] && bus.page_sel[bus.addr[15:14]];
          cnt_d   = '0;
          fcnt_d  = '0;
          if (bus.op[0]) dout_d = bus.wdata;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: begin
        // I/O cycles get their forced TW states before wait_n is looked at
        if (op_q[1] && (IO_WAITS > 0)) begin
          state_d = S_TW;
          fcnt_d  = FW_INIT;
        end else if (!bus.wait_n) begin
          state_d = S_TW;
          cnt_d   = CW'(1);
        end else begin
          state_d = S_T3;
        end
      end
      S_TW: begin
        if (fcnt_q != '0) begin
          fcnt_d = fcnt_q - 1'b1;
        end else if (bus.wait_n) begin
          state_d = S_T3;
        end else if ((WAIT_TIMEOUT != 0) && (cnt_q >= TO_LIM)) begin
          state_d = S_TE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_T3: begin
        if (!op_q[0]) rdata_d = bus.d_in;
        state_d = S_TE;
        done_d  = 1'b1;
      end
      S_TE:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they change only on clk edges.
    strobe_on = (state_d == S_T2) || (state_d == S_TW) || (state_d == S_T3);
    mreq_n_d  = !(strobe_on && !op_q[1]);
    iorq_n_d  = !(strobe_on && op_q[1]);
    rd_n_d    = !(strobe_on && !op_q[0]);
    wr_n_d    = !(strobe_on && op_q[0]);
    sltsl_n_d = !(strobe_on && sel_q);
    doe_d     = (state_d != S_IDLE) && op_d[0];
    ready_d   = (state_d == S_IDLE);
  end

  assign bus.ready   = ready_q;
  assign bus.rdata   = rdata_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.a       = a_q;
  assign bus.d_out   = dout_q;
  assign bus.d_oe    = doe_q;
  assign bus.mreq_n  = mreq_n_q;
  assign bus.iorq_n  = iorq_n_q;
  assign bus.rd_n    = rd_n_q;
  assign bus.wr_n    = wr_n_q;
  assign bus.sltsl_n = sltsl_n_q;
endmodule

// File: tb/tb_msx_bus_initiator.sv
// Directed bench for msx_bus_initiator: memory/I/O cycles, waits, timeout, reset, back-to-back.
// Cycle labels follow the edge that ends the cycle, so the cycle after accept edge k is k+1.
module tb_msx_bus_initiator;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  int c_mreq = 0, c_iorq = 0, c_rd = 0, c_wr = 0, c_slt = 0, c_oe = 0, c_done = 0, c_bad = 0;
  int s_mreq, s_iorq, s_rd, s_wr, s_slt, s_oe, s_done;
  int k, dc, d1, d2;

  logic [4:0] strb;

  msx_bus_initiator_if bus();

  msx_bus_initiator #(.IO_WAITS(1), .WAIT_TIMEOUT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign strb = {bus.mreq_n, bus.iorq_n, bus.rd_n, bus.wr_n, bus.sltsl_n};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle strobe activity, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.mreq_n === 1'b0)  c_mreq <= c_mreq + 1;
    if (bus.iorq_n === 1'b0)  c_iorq <= c_iorq + 1;
    if (bus.rd_n === 1'b0)    c_rd   <= c_rd + 1;
    if (bus.wr_n === 1'b0)    c_wr   <= c_wr + 1;
    if (bus.sltsl_n === 1'b0) c_slt  <= c_slt + 1;
    if (bus.d_oe === 1'b1)    c_oe   <= c_oe + 1;
    if (bus.done === 1'b1)    c_done <= c_done + 1;
    if ((bus.mreq_n === 1'b0 && bus.iorq_n === 1'b0) ||
        (bus.iorq_n === 1'b0 && bus.sltsl_n === 1'b0)) c_bad <= c_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_mreq = c_mreq; s_iorq = c_iorq; s_rd = c_rd; s_wr = c_wr;
    s_slt = c_slt; s_oe = c_oe; s_done = c_done;
  endtask

  // Called at posedge+1 with the DUT idle; returns the accepting edge number.
  task automatic start_req(input logic [1:0] op, input logic [15:0] ad, input logic [7:0] wd,
                           input logic [3:0] ps, output int kk);
    bus.req = 1'b1; bus.op = op; bus.addr = ad; bus.wdata = wd; bus.page_sel = ps;
    @(posedge clk); #1;
    kk = cyc;
    bus.req = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dcyc = cyc + 1;
        break;
      end
    end
  endtask

  initial begin
    bus.req = 1'b0; bus.op = 2'b00; bus.addr = 16'h0; bus.wdata = 8'h0;
    bus.page_sel = 4'h0; bus.d_in = 8'h0; bus.wait_n = 1'b1;

    // Reset state
    #12;
    chk("rst_strobes", strb, 5'h1f);
    chk("rst_a", bus.a, 16'h0);
    chk("rst_dout", bus.d_out, 8'h0);
    chk("rst_doe", bus.d_oe, 1'b0);
    chk("rst_rdata", bus.rdata, 8'h0);
    chk("rst_done_err", {bus.done, bus.err}, 2'b00);
    chk("rst_ready", bus.ready, 1'b1);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // Memory write, page 1 selected, no waits
    snap();
    start_req(2'b01, 16'h5000, 8'h05, 4'b0010, k);
    wait_done(20, dc);
    chk("wr_done_cyc", dc, k + 4);
    chk("wr_err", bus.err, 1'b0);
    chk("wr_dout", bus.d_out, 8'h05);
    @(posedge clk); #1;
    chk("wr_ready", bus.ready, 1'b1);
    chk("wr_doe_off", bus.d_oe, 1'b0);
    chk("wr_a", bus.a, 16'h5000);
    chk("wr_mreq_cnt", c_mreq - s_mreq, 2);
    chk("wr_wr_cnt", c_wr - s_wr, 2);
    chk("wr_slt_cnt", c_slt - s_slt, 2);
    chk("wr_rd_cnt", c_rd - s_rd, 0);
    chk("wr_oe_cnt", c_oe - s_oe, 4);

    // Memory read with three slave wait samples
    bus.d_in = 8'hA5; bus.wait_n = 1'b0;
    snap();
    start_req(2'b00, 16'h4000, 8'h00, 4'b0010, k);
    repeat (4) @(posedge clk);
    #1 bus.wait_n = 1'b1;
    wait_done(20, dc);
    chk("rdw_done_cyc", dc, k + 7);
    chk("rdw_rdata", bus.rdata, 8'hA5);
    @(posedge clk); #1;
    chk("rdw_mreq_cnt", c_mreq - s_mreq, 5);
    chk("rdw_rd_cnt", c_rd - s_rd, 5);
    chk("rdw_slt_cnt", c_slt - s_slt, 5);
    chk("rdw_oe_cnt", c_oe - s_oe, 0);

    // I/O read: one forced TW, slot select must stay off
    bus.d_in = 8'h3C;
    snap();
    start_req(2'b10, 16'h0011, 8'h00, 4'b1111, k);
    wait_done(20, dc);
    chk("io_done_cyc", dc, k + 5);
    chk("io_rdata", bus.rdata, 8'h3C);
    @(posedge clk); #1;
    chk("io_iorq_cnt", c_iorq - s_iorq, 3);
    chk("io_rd_cnt", c_rd - s_rd, 3);
    chk("io_mreq_cnt", c_mreq - s_mreq, 0);
    chk("io_slt_cnt", c_slt - s_slt, 0);

    // Wait timeout: wait_n stuck low
    bus.d_in = 8'h77; bus.wait_n = 1'b0;
    snap();
    start_req(2'b00, 16'h4000, 8'h00, 4'b0010, k);
    wait_done(20, dc);
    chk("to_done_cyc", dc, k + 7);
    chk("to_err", bus.err, 1'b1);
    chk("to_strobes", strb, 5'h1f);
    chk("to_rdata_kept", bus.rdata, 8'h3C);
    @(posedge clk); #1;
    bus.wait_n = 1'b1;
    chk("to_mreq_cnt", c_mreq - s_mreq, 5);
    chk("to_done_cnt", c_done - s_done, 1);

    // Reset asserted in TW of a memory write
    bus.wait_n = 1'b0;
    snap();
    start_req(2'b01, 16'h2000, 8'h5A, 4'b0001, k);
    repeat (3) @(negedge clk);
    chk("mid_in_tw", {bus.mreq_n, bus.wr_n, bus.d_oe}, 3'b001);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_strobes", strb, 5'h1f);
    chk("mid_doe", bus.d_oe, 1'b0);
    chk("mid_ready", bus.ready, 1'b1);
    chk("mid_done", bus.done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    bus.wait_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_no_done", c_done - s_done, 0);

    // Following request, page_sel=0: slot select never asserted
    bus.d_in = 8'hC3;
    snap();
    start_req(2'b00, 16'h6000, 8'h00, 4'b0000, k);
    wait_done(20, dc);
    chk("post_done_cyc", dc, k + 4);
    chk("post_rdata", bus.rdata, 8'hC3);
    chk("post_err", bus.err, 1'b0);
    @(posedge clk); #1;
    chk("post_slt_cnt", c_slt - s_slt, 0);
    chk("post_mreq_cnt", c_mreq - s_mreq, 2);

    // Back-to-back reads with req held high
    bus.d_in = 8'h11;
    snap();
    bus.req = 1'b1; bus.op = 2'b00; bus.addr = 16'h8000; bus.page_sel = 4'b1100;
    @(posedge clk); #1;
    k = cyc;
    bus.addr = 16'hA000;
    d1 = -1; d2 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (d1 < 0) begin
          d1 = cyc + 1;
          chk("b2b_rdata1", bus.rdata, 8'h11);
          bus.d_in = 8'h22;
        end else begin
          d2 = cyc + 1;
          bus.req = 1'b0;
          break;
        end
      end
    end
    bus.req = 1'b0;
    @(posedge clk); #1;
    chk("b2b_done1_cyc", d1, k + 4);
    chk("b2b_done2_cyc", d2, k + 9);
    chk("b2b_rdata2", bus.rdata, 8'h22);
    chk("b2b_a", bus.a, 16'hA000);
    chk("b2b_slt_cnt", c_slt - s_slt, 4);
    chk("b2b_done_cnt", c_done - s_done, 2);

    chk("never_mreq_iorq_or_io_slt", c_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/msx_bus_initiator.md
Name: msx_bus_initiator

Overview:
- Bus-master side of the MSX cartridge slot interface.
- Generates Z80-timed memory and I/O read/write cycles on the slot signals (A15..A0, D7..D0, mreq_n, iorq_n, rd_n, wr_n, sltsl_n, wait_n) from a simple request/done handshake.
- Drives the mapper and CH376 cartridge logic in bench and in-system host-emulation builds.
- One T-state equals one clk period.

Parameters:
- IO_WAITS, 1, automatic wait states inserted in every I/O cycle (the Z80 forced TW).
- WAIT_TIMEOUT, 255, maximum consecutive wait_n-low TW states before the cycle is aborted; 0 disables the timeout.

Ports:
- clk  in  1  T-state clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  cycle request; accepted when req && ready.
- ready  out  1  high in IDLE only.
- op  in  2  operation: 00 mem read, 01 mem write, 10 io read, 11 io write.
- addr  in  16  cycle address.
- wdata  in  8  write data.
- page_sel  in  4  bit n set = sltsl_n asserted for memory cycles to page n (addr[15:14]==n).
- rdata  out  8  captured read data.
- done  out  1  one-clk pulse at cycle end.
- err  out  1  with done: cycle aborted by wait timeout.
- a  out  16  bus address.
- d_out  out  8  bus write data.
- d_oe  out  1  data bus drive enable.
- d_in  in  8  bus read data.
- mreq_n, iorq_n, rd_n, wr_n, sltsl_n  out  1 each  bus strobes.
- wait_n  in  1  slave wait request, synchronous to clk.

Behaviour:
- Reset (async, any state):
  - State IDLE.
  - a=0, d_out=0, d_oe=0, rdata=0, done=0, err=0, ready=1.
  - All strobes high; no strobe glitch is permitted on reset assertion.
- Request capture: op, addr, wdata and page_sel are registered on the accepting edge. Inputs are ignored outside IDLE.
- States: IDLE -> T1 -> T2 -> [TW]* -> T3 -> TE -> IDLE.
- T1:
  - a = captured addr; strobes high.
  - Writes: d_out = wdata, d_oe=1. d_oe stays high through TE.
- T2 and T3: active strobes low.
  - Memory cycles: mreq_n.
  - I/O cycles: iorq_n.
  - Reads: rd_n.
  - Writes: wr_n.
  - sltsl_n low only for memory cycles with page_sel[addr[15:14]]=1.
  - iorq_n and mreq_n are never low together. sltsl_n is never low in I/O cycles.
- TW: strobes held low; a and d_out stable.
- T2 exit:
  - I/O cycle: enter IO_WAITS forced TW states, then sample wait_n.
  - Memory cycle: sample wait_n at the end of T2.
  - wait_n=0 -> TW; TW repeats while wait_n=0 at the end of each TW.
  - wait_n=1 -> T3.
- Timeout:
  - Counter of wait_n-low TW states (8 bits minimum, saturating).
  - When it reaches WAIT_TIMEOUT (nonzero), go to TE with err=1, rdata unchanged, strobes released.
- End of T3, reads: rdata <= d_in.
- TE:
  - All strobes high; a held; d_oe=0 at the TE->IDLE edge.
  - done=1 for exactly one clk; err valid with done.
- IDLE: a keeps its last value; ready=1.
  - Back-to-back: req held high is accepted in the first IDLE cycle after TE.
- Latency, req accepted at edge k with no slave waits:
  - Memory cycle: T1 at k+1, done high during k+4, ready again at k+5.
  - I/O cycle with IO_WAITS=1: done high during k+5.
- Boundaries:
  - wait_n is ignored outside the sample points.
  - page_sel=0 gives a memory cycle with sltsl_n high throughout; the cycle still completes.
  - Reset mid-cycle releases all strobes immediately; no done is issued.

Test Plan:
- Memory write: op=01, addr=5000h, wdata=05h, page_sel=0010b.
  - sltsl_n, mreq_n and wr_n low for exactly 2 clks (T2, T3).
  - d_oe=1 T1..TE, d_out=05h.
  - done at k+4, err=0. The mapper subsequently selects bank 5 for 4000h reads.
- Memory read: op=00, addr=4000h, d_in=A5h, wait_n held 0 for 3 samples.
  - 3 TW states; strobes low 5 clks; rdata=A5h; done at k+7.
- I/O read: op=10, addr=0011h, d_in=3Ch, IO_WAITS=1.
  - iorq_n and rd_n low 3 clks; mreq_n and sltsl_n high throughout.
  - rdata=3Ch; done at k+5.
- Timeout: WAIT_TIMEOUT=4, wait_n stuck 0.
  - Exactly 4 TW states, then TE with done=1, err=1.
  - rdata keeps its prior value; strobes high.
- Reset during TW of a memory write.
  - All strobes high and d_oe=0 asynchronously; ready=1; no done pulse.
  - A following request completes normally.
- Back-to-back: req held high for two memory reads at addr=8000h, then A000h, page_sel=1100b.
  - Second T1 immediately follows the first TE's IDLE cycle.
  - sltsl_n low in both cycles; two done pulses 5 clks apart.
